// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through one- or two-byte opcodes,
// presents the captured instruction to execute, and follows branch/halt requests.
module fetch_ctrl #(
  parameter logic [3:0] LONG_MIN = 4'hC,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [11:0]      pc_addr,
  input  logic [7:0]       rom_data,
  input  logic             exec_done,
  input  logic             branch,
  input  logic [11:0]      branch_target,
  input  logic             halt,
  output logic             incPC,
  output logic             loadPC,
  output logic [11:0]      newaddr,
  output logic [7:0]       instr,
  output logic [7:0]       operand,
  output logic [11:0]      instr_addr,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_F1    = 3'd1;
  localparam logic [2:0] S_F2    = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       handshake;
  logic       is_long;
  logic       take_branch;

  // Handshake: instr_valid is the valid, exec_done the ready. A transfer happens
  // on a rising edge where both are high; instr/operand/instr_addr hold until then.
  assign handshake   = (state == S_ISSUE) && exec_done;
  assign take_branch = handshake && branch && !halt;
  assign is_long     = (rom_data[7:4] >= LONG_MIN);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_F1;
      S_F1:    next_state = is_long ? S_F2 : S_ISSUE;
      S_F2:    next_state = S_ISSUE;
      S_ISSUE: begin
        if (handshake) next_state = halt ? S_HALT : S_F1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  assign incPC       = (state == S_F1) || (state == S_F2);
  assign loadPC      = take_branch;
  assign newaddr     = take_branch ? branch_target : 12'h000;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      instr      <= 8'h00;
      operand    <= 8'h00;
      instr_addr <= 12'h000;
      retired    <= '0;
    end else begin
      state <= next_state;
      if (state == S_F1) begin
        instr      <= rom_data;
        instr_addr <= pc_addr;
        operand    <= 8'h00;
      end
      if (state == S_F2) operand <= rom_data;
      if (handshake) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, reset-in-F2 sequence, and a
// randomized run checked against an instruction-level fetch model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic [11:0] pc;
  logic [7:0]  rom [4096];
  logic [7:0]  rom_data;
  logic        exec_done = 1'b0, branch = 1'b0, halt = 1'b0;
  logic [11:0] branch_target = 12'h000;
  logic        incPC, loadPC, instr_valid, halted;
  logic [11:0] newaddr, instr_addr;
  logic [7:0]  instr, operand;
  logic [15:0] retired;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk(clk), .Rst(Rst), .pc_addr(pc), .rom_data(rom_data),
    .exec_done(exec_done), .branch(branch), .branch_target(branch_target), .halt(halt),
    .incPC(incPC), .loadPC(loadPC), .newaddr(newaddr), .instr(instr), .operand(operand),
    .instr_addr(instr_addr), .instr_valid(instr_valid), .halted(halted),
    .retired(retired), .dbg_state(dbg_state)
  );

  // Clock / reset environment: the PC register lives in the bench.
  always #5 clk = ~clk;

  always @(posedge clk or posedge Rst) begin
    if (Rst) pc <= 12'h000;
    else if (loadPC) pc <= newaddr;
    else if (incPC) pc <= pc + 12'd1;
  end

  assign rom_data = rom[pc];

  function automatic logic [59:0] obs();
    return {incPC, loadPC, newaddr, instr_valid, halted, instr, operand, instr_addr, retired};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 ns later (well before the rising edge).
  task automatic drive(input logic ed, input logic br, input logic hl, input logic [11:0] tgt);
    @(negedge clk);
    exec_done = ed; branch = br; halt = hl; branch_target = tgt;
    #1;
  endtask

  // Asserts reset part-way through the current cycle, then releases on a falling edge.
  task automatic do_reset();
    #2;
    Rst = 1'b1; exec_done = 1'b1; branch = 1'b1; halt = 1'b0; branch_target = 12'hABC;
    #1;
    chk("reset_imm", 64'(obs()), 64'(0));
    chk("reset_pc", 64'(pc), 64'(0));
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_hold", 64'({incPC, loadPC, instr_valid, halted, retired}), 64'(0));
    end
    @(negedge clk);
    Rst = 1'b0;
    #1;
    chk("idle_after_rst", 64'({incPC, loadPC, instr_valid, halted}), 64'(0));
  endtask

  typedef struct {
    logic ed, br, hl; logic [11:0] tgt;
    logic inc, ld; logic [11:0] na; logic v, h;
    logic [7:0] ins, op; logic [11:0] addr; logic [15:0] ret;
  } vec_t;

  function automatic vec_t mk(logic ed, logic br, logic hl, logic [11:0] tgt,
                              logic inc, logic ld, logic [11:0] na, logic v, logic h,
                              logic [7:0] ins, logic [7:0] op, logic [11:0] addr, logic [15:0] ret);
    vec_t r;
    r.ed = ed; r.br = br; r.hl = hl; r.tgt = tgt; r.inc = inc; r.ld = ld; r.na = na;
    r.v = v; r.h = h; r.ins = ins; r.op = op; r.addr = addr; r.ret = ret;
    return r;
  endfunction

  vec_t tbl [18];

  // Reference model state: instruction-level view of the fetch stream.
  logic [11:0] mpc;
  logic [15:0] m_ret;
  int          gap, inc_cnt, halt_cycles;
  logic        in_issue, m_halted;

  task automatic model_reset();
    mpc = 12'h000; m_ret = 16'h0000; gap = 0; inc_cnt = 0;
    halt_cycles = 0; in_issue = 1'b0; m_halted = 1'b0;
  endtask

  initial begin
    logic ed, br, hl, lb, rst_now;
    logic [11:0] tgt, nxt;
    logic [7:0]  b0, b1;
    int len;

    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0] = 8'h12; rom[1] = 8'hC3; rom[2] = 8'h45; rom[3] = 8'h20;
    rom[12'h0D0] = 8'hD7; rom[12'h0D1] = 8'h99;

    // Directed table: one row per cycle starting at the first F1 after reset.
    //             ed  br  hl  tgt      inc ld na      v  h  ins    op     addr    ret
    tbl[0]  = mk(1, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 8'h00, 8'h00, 12'h000, 0);
    tbl[1]  = mk(1, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 8'h12, 8'h00, 12'h000, 0);
    tbl[2]  = mk(1, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 8'h12, 8'h00, 12'h000, 1);
    tbl[3]  = mk(1, 1, 1, 12'h123, 1, 0, 12'h000, 0, 0, 8'hC3, 8'h00, 12'h001, 1);
    tbl[4]  = mk(1, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 8'hC3, 8'h45, 12'h001, 1);
    tbl[5]  = mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 8'hC3, 8'h45, 12'h001, 2);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(0, 1, 0, 12'h777, 0, 0, 12'h000, 1, 0, 8'h20, 8'h00, 12'h003, 2);
    tbl[11] = mk(1, 1, 0, 12'h0D0, 0, 1, 12'h0D0, 1, 0, 8'h20, 8'h00, 12'h003, 2);
    tbl[12] = mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 8'h20, 8'h00, 12'h003, 3);
    tbl[13] = mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 8'hD7, 8'h00, 12'h0D0, 3);
    tbl[14] = mk(1, 1, 1, 12'h555, 0, 0, 12'h000, 1, 0, 8'hD7, 8'h99, 12'h0D0, 3);
    for (int i = 15; i <= 17; i++)
      tbl[i] = mk(1, 1, 0, 12'h321, 0, 0, 12'h000, 0, 1, 8'hD7, 8'h99, 12'h0D0, 4);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ed, tbl[i].br, tbl[i].hl, tbl[i].tgt);
      chk($sformatf("vec%0d", i), 64'(obs()),
          64'({tbl[i].inc, tbl[i].ld, tbl[i].na, tbl[i].v, tbl[i].h,
               tbl[i].ins, tbl[i].op, tbl[i].addr, tbl[i].ret}));
    end

    // Reset in the middle of F2 discards the long instruction; refetch from 0.
    rom[0] = 8'hC1; rom[1] = 8'h5A;
    do_reset();
    drive(0, 0, 0, 12'h000);
    chk("r43_f1", 64'({incPC, pc}), 64'({1'b1, 12'h000}));
    drive(0, 0, 0, 12'h000);
    chk("r43_f2", 64'({incPC, instr, instr_addr}), 64'({1'b1, 8'hC1, 12'h000}));
    do_reset();
    drive(0, 0, 0, 12'h000);
    chk("r43_refetch_f1", 64'({incPC, pc, instr}), 64'({1'b1, 12'h000, 8'h00}));
    drive(0, 0, 0, 12'h000);
    chk("r43_refetch_f2", 64'({incPC, pc}), 64'({1'b1, 12'h001}));
    drive(0, 0, 0, 12'h000);
    chk("r43_issue", 64'({instr_valid, instr, operand, instr_addr, retired}),
        64'({1'b1, 8'hC1, 8'h5A, 12'h000, 16'h0000}));

    // Randomized run against the instruction-level model.
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[12'hFFF] = 8'hE7;
    do_reset();
    model_reset();
    for (int c = 0; c < 5000; c++) begin
      ed  = ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 3) == 0);
      hl  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
      rst_now = 1'b0;
      drive(ed, br, hl, tgt);
      chk("strobe_excl", 64'(incPC & loadPC), 64'(0));
      if (m_halted) begin
        chk("halt_outs", 64'({halted, incPC, loadPC, instr_valid, newaddr}), 64'({1'b1, 15'h0}));
        chk("halt_retired", 64'(retired), 64'(m_ret));
        halt_cycles++;
        if (halt_cycles == 3) rst_now = 1'b1;
      end else if (instr_valid) begin
        nxt = mpc + 12'd1;
        b0  = rom[mpc];
        lb  = (b0[7:4] >= 4'hC);
        len = lb ? 2 : 1;
        b1  = lb ? rom[nxt] : 8'h00;
        if (!in_issue) begin
          chk("fetch_gap", 64'(gap), 64'(len));
          chk("inc_count", 64'(inc_cnt), 64'(len));
          in_issue = 1'b1;
        end
        chk("issue_fields", 64'({instr, operand, instr_addr}), 64'({b0, b1, mpc}));
        chk("issue_retired", 64'(retired), 64'(m_ret));
        chk("issue_strobes", 64'({incPC, loadPC, newaddr, halted}),
            64'({1'b0, ed & br & !hl, (ed & br & !hl) ? tgt : 12'h000, 1'b0}));
        if (ed) begin
          m_ret = m_ret + 16'd1;
          in_issue = 1'b0; gap = 0; inc_cnt = 0;
          if (hl) m_halted = 1'b1;
          else if (br) mpc = tgt;
          else mpc = mpc + 12'(len);
        end
      end else begin
        gap++;
        if (incPC) inc_cnt++;
        chk("fetch_strobes", 64'({loadPC, newaddr, halted}), 64'(0));
        chk("fetch_retired", 64'(retired), 64'(m_ret));
        if (gap > 2) begin
          chk("fetch_timeout", 64'(gap), 64'(2));
          rst_now = 1'b1;
        end
      end
      if (!rst_now && $urandom_range(0, 299) == 0) rst_now = 1'b1;
      if (rst_now) begin
        do_reset();
        model_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter LONG_MIN, default 4'hC: opcodes with rom_data[7:4] >= LONG_MIN are two-byte instructions; all others are one-byte.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_addr  input  12  current PC value (PC.addr).
REQ-006 rom_data  input  8  ROM byte at pc_addr, combinational.
REQ-007 exec_done  input  1  execute stage consumed the issued instruction this cycle.
REQ-008 branch  input  1  qualified by exec_done: redirect fetch to branch_target.
REQ-009 branch_target  input  12  redirect address.
REQ-010 halt  input  1  qualified by exec_done: stop fetching.
REQ-011 incPC  output  1  PC increment strobe.
REQ-012 loadPC  output  1  PC load strobe.
REQ-013 newaddr  output  12  PC load value.
REQ-014 instr  output  8  captured opcode byte.
REQ-015 operand  output  8  captured second byte; 8'h00 for one-byte instructions.
REQ-016 instr_addr  output  12  pc_addr at which instr was fetched.
REQ-017 instr_valid  output  1  instr/operand/instr_addr valid for execute.
REQ-018 halted  output  1  controller in HALT.
REQ-019 retired  output  CNT_W  count of exec_done handshakes.

Function
REQ-020 States: IDLE, F1, F2, ISSUE, HALT; IDLE -> F1 unconditionally after one cycle.
REQ-021 F1: incPC=1; at edge instr<=rom_data, instr_addr<=pc_addr, operand<=8'h00; next F2 if rom_data[7:4]>=LONG_MIN, else ISSUE.
REQ-022 F2: incPC=1; at edge operand<=rom_data; next ISSUE.
REQ-023 ISSUE: instr_valid=1, incPC=0; held stable until exec_done=1.
REQ-024 ISSUE & exec_done & halt: next HALT; halt has priority over branch; loadPC=0.
REQ-025 ISSUE & exec_done & branch & !halt: loadPC=1 and newaddr=branch_target combinationally that cycle; next F1.
REQ-026 ISSUE & exec_done & !branch & !halt: next F1, loadPC=0.
REQ-027 newaddr=12'h000 whenever loadPC=0.
REQ-028 incPC and loadPC never both 1; incPC is a pure function of state (F1, F2); loadPC as REQ-025 only.
REQ-029 exec_done, branch, halt ignored outside ISSUE.
REQ-030 HALT: incPC=0, loadPC=0, instr_valid=0, halted=1; left only by Rst.
REQ-031 retired increments by 1 at each ISSUE & exec_done edge (including halt/branch); wraps all-ones -> 0.
REQ-032 Latency: one-byte instruction valid 2 cycles after F1 entry... precisely: F1 one cycle, ISSUE next cycle; two-byte adds one cycle (F2).
REQ-033 PC wrap 12'hFFF -> 12'h000 owned by PC; controller places no restriction on fetch at 12'hFFF, including the second byte of a long instruction at 12'h000.
REQ-034 Back-to-back: exec_done in first ISSUE cycle yields F1 on the next cycle; no bubble cycles beyond F1/F2.

Reset
REQ-035 Rst=1 asynchronously forces state IDLE, instr=8'h00, operand=8'h00, instr_addr=12'h000, instr_valid=0, incPC=0, loadPC=0, newaddr=12'h000, halted=0, retired=0.
REQ-036 Rst asserted mid-F2 or mid-ISSUE discards the partial instruction; first F1 after release fetches from PC's own reset value.
REQ-037 Controller is held in IDLE for every cycle Rst=1.

Verification
REQ-038 ROM[0]=8'h12, exec_done=1 constant -> F1,ISSUE: instr=8'h12, operand=8'h00, instr_addr=0, incPC pulsed once, retired=1.
REQ-039 ROM[1]=8'hC3, ROM[2]=8'h45 -> F1,F2,ISSUE: instr=8'hC3, operand=8'h45, instr_addr=1, two incPC pulses, next fetch at 3.
REQ-040 ISSUE with exec_done=0 for 5 cycles -> instr_valid=1 and outputs stable 5 cycles, no incPC, retired unchanged.
REQ-041 exec_done=1, branch=1, branch_target=12'h0D0 -> loadPC=1, newaddr=12'h0D0 that cycle, next instr_addr=12'h0D0.
REQ-042 exec_done=1, halt=1, branch=1 -> HALT, loadPC=0, halted=1, no further strobes until Rst.
REQ-043 Rst pulsed during F2 of a long instruction -> all outputs to REQ-035 values immediately, then clean fetch from PC reset address.
